prf_free_list: RTL and testbench

PRF_FREE_LIST -- requirements
Module: prf_free_list

---
 rtl/prf_free_list_pkg.sv | 16 +
 rtl/prf_free_list_psel.sv | 38 +++
 rtl/prf_free_list.sv | 122 ++++++++++++
 tb/tb_prf_free_list.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/prf_free_list_pkg.sv
// Shared defaults for the physical register file free list and its consumers.
package prf_free_list_pkg;

    localparam int unsigned FL_N           = 3;
    localparam int unsigned FL_PRF_ENTRIES = 64;
    localparam int unsigned FL_IDX_BITS    = 6;
    localparam int unsigned FL_ARCH_REGS   = 32;

    typedef enum logic [1:0] {
        FL_OP_RESET,
        FL_OP_RECOVER,
        FL_OP_ALLOC,
        FL_OP_IDLE
    } fl_op_e;

endpackage

// File: rtl/prf_free_list_psel.sv
// N-way lowest-index priority selector: each requesting lane, in lane order,
// takes the lowest free entry not already taken by an earlier lane.
module prf_free_list_psel
    import prf_free_list_pkg::*;
#(
    parameter int unsigned N        = FL_N,
    parameter int unsigned ENTRIES  = FL_PRF_ENTRIES,
    parameter int unsigned IDX_BITS = FL_IDX_BITS
)(
    input  logic [ENTRIES-1:0]             i_bitmap,
    input  logic [N-1:0]                   i_req,
    output logic [N-1:0][IDX_BITS-1:0]     o_idx,
    output logic [N-1:0]                   o_vld
);

    logic [ENTRIES-1:0] w_avail;

    always_comb begin
        w_avail = i_bitmap;
        o_idx   = '0;
        o_vld   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (i_req[k]) begin
                // Scan high to low so the last hit is the lowest free index.
                for (int unsigned j = 0; j < ENTRIES; j++) begin
                    if (w_avail[ENTRIES-1-j]) begin
                        o_idx[k] = IDX_BITS'(ENTRIES-1-j);
                        o_vld[k] = 1'b1;
                    end
                end
                if (o_vld[k]) begin
                    w_avail[o_idx[k]] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/prf_free_list.sv
// Physical register free list with all-or-nothing N-lane allocation and recovery.
// Optional sticky double-free detection: define FREELIST_DBL_FREE_CHECK_EN.
module prf_free_list
    import prf_free_list_pkg::*;
#(
    parameter int unsigned N           = FL_N,
    parameter int unsigned PRF_ENTRIES = FL_PRF_ENTRIES,
    parameter int unsigned IDX_BITS    = FL_IDX_BITS,
    parameter int unsigned ARCH_REGS   = FL_ARCH_REGS
)(
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N-1:0]                  alloc_req,
    input  logic [PRF_ENTRIES-1:0]        free_vec,
    input  logic                          recover,
    input  logic [PRF_ENTRIES-1:0]        recover_free_vec,
    output logic [N-1:0][IDX_BITS-1:0]    alloc_idx,
    output logic [N-1:0]                  alloc_gnt,
    output logic                          stall,
    output logic [IDX_BITS:0]             free_count,
    output logic                          dbl_free_err
);

    logic [PRF_ENTRIES-1:0]       r_bitmap;
    logic [IDX_BITS:0]            r_free_count;

    logic [N-1:0][IDX_BITS-1:0]   w_sel_idx;
    logic [N-1:0]                 w_sel_vld;
    logic [IDX_BITS:0]            w_req_cnt;
    logic                         w_fits;
    fl_op_e                       w_op;
    logic [PRF_ENTRIES-1:0]       w_gnt_mask;
    logic [PRF_ENTRIES-1:0]       w_bitmap_nxt;
    logic [IDX_BITS:0]            w_count_nxt;

    prf_free_list_psel #(
        .N        (N),
        .ENTRIES  (PRF_ENTRIES),
        .IDX_BITS (IDX_BITS)
    ) u_psel (
        .i_bitmap (r_bitmap),
        .i_req    (alloc_req),
        .o_idx    (w_sel_idx),
        .o_vld    (w_sel_vld)
    );

    always_comb begin
        w_req_cnt = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_req_cnt = w_req_cnt + (IDX_BITS+1)'(alloc_req[k]);
        end
        w_fits = (w_req_cnt <= r_free_count);

        if (reset)                      w_op = FL_OP_RESET;
        else if (recover)               w_op = FL_OP_RECOVER;
        else if (|alloc_req && w_fits)  w_op = FL_OP_ALLOC;
        else                            w_op = FL_OP_IDLE;
    end

    always_comb begin
        alloc_gnt  = '0;
        alloc_idx  = '0;
        stall      = 1'b0;
        w_gnt_mask = '0;
        unique case (w_op)
            FL_OP_RESET, FL_OP_RECOVER: stall = 1'b1;
            FL_OP_ALLOC: begin
                for (int unsigned k = 0; k < N; k++) begin
                    if (alloc_req[k] && w_sel_vld[k]) begin
                        alloc_gnt[k]            = 1'b1;
                        alloc_idx[k]            = w_sel_idx[k];
                        w_gnt_mask[w_sel_idx[k]] = 1'b1;
                    end
                end
            end
            default: stall = !w_fits;
        endcase
    end

    // Count is rebuilt from the next bitmap so it can never drift from it.
    always_comb begin
        if (w_op == FL_OP_RECOVER) w_bitmap_nxt = recover_free_vec | free_vec;
        else                       w_bitmap_nxt = (r_bitmap & ~w_gnt_mask) | free_vec;
        w_bitmap_nxt[0] = 1'b0;
        w_count_nxt = '0;
        for (int unsigned i = 0; i < PRF_ENTRIES; i++) begin
            w_count_nxt = w_count_nxt + (IDX_BITS+1)'(w_bitmap_nxt[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < PRF_ENTRIES; i++) begin
                r_bitmap[i] <= (i >= ARCH_REGS);
            end
            r_free_count <= (IDX_BITS+1)'(PRF_ENTRIES - ARCH_REGS);
        end else begin
            r_bitmap     <= w_bitmap_nxt;
            r_free_count <= w_count_nxt;
        end
    end

    assign free_count = r_free_count;

`ifdef FREELIST_DBL_FREE_CHECK_EN
    logic r_dbl_free_err;
    logic w_dbl_hit;

    assign w_dbl_hit = |(free_vec[PRF_ENTRIES-1:1] &
                         (r_bitmap[PRF_ENTRIES-1:1] | w_gnt_mask[PRF_ENTRIES-1:1]));

    always_ff @(posedge clock) begin
        if (reset)          r_dbl_free_err <= 1'b0;
        else if (w_dbl_hit) r_dbl_free_err <= 1'b1;
    end

    assign dbl_free_err = r_dbl_free_err;
`else
    assign dbl_free_err = 1'b0;
`endif

endmodule

// File: tb/tb_prf_free_list.sv
// Directed bench for prf_free_list: vector table plus hand-built corner sequences.
module tb_prf_free_list;

    localparam int unsigned N  = 3;
    localparam int unsigned PE = 64;
    localparam int unsigned IB = 6;
`ifdef FREELIST_DBL_FREE_CHECK_EN
    localparam bit DBL_EN = 1'b1;
`else
    localparam bit DBL_EN = 1'b0;
`endif

    logic                    clock = 1'b0;
    logic                    reset;
    logic [N-1:0]            alloc_req;
    logic [PE-1:0]           free_vec;
    logic                    recover;
    logic [PE-1:0]           recover_free_vec;
    logic [N-1:0][IB-1:0]    alloc_idx;
    logic [N-1:0]            alloc_gnt;
    logic                    stall;
    logic [IB:0]             free_count;
    logic                    dbl_free_err;

    int checks = 0;
    int errors = 0;
    logic exp_dbl = 1'b0;

    prf_free_list #(
        .N           (N),
        .PRF_ENTRIES (PE),
        .IDX_BITS    (IB),
        .ARCH_REGS   (32)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .alloc_req        (alloc_req),
        .free_vec         (free_vec),
        .recover          (recover),
        .recover_free_vec (recover_free_vec),
        .alloc_idx        (alloc_idx),
        .alloc_gnt        (alloc_gnt),
        .stall            (stall),
        .free_count       (free_count),
        .dbl_free_err     (dbl_free_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0]         req;
        logic [PE-1:0]        fv;
        logic [N-1:0]         gnt;
        logic [N-1:0][IB-1:0] idx;
        logic                 stall;
        int                   cnt;
    } vec_t;

    vec_t tbl[6];

    function automatic vec_t mk(input logic [N-1:0] req, input logic [PE-1:0] fv,
                                input logic [N-1:0] gnt, input int i2, input int i1,
                                input int i0, input logic stl, input int cnt);
        vec_t v;
        v.req    = req;
        v.fv     = fv;
        v.gnt    = gnt;
        v.idx[2] = IB'(i2);
        v.idx[1] = IB'(i1);
        v.idx[0] = IB'(i0);
        v.stall  = stl;
        v.cnt    = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Drive one cycle at negedge, check combinational outputs and the current count.
    task automatic apply(input string name, input logic rst, input logic rec,
                         input logic [PE-1:0] rfv, input vec_t v);
        @(negedge clock);
        reset            = rst;
        recover          = rec;
        recover_free_vec = rfv;
        alloc_req        = v.req;
        free_vec         = v.fv;
        #1;
        chk({name, ".gnt"},   64'(alloc_gnt),    64'(v.gnt));
        chk({name, ".idx"},   64'(alloc_idx),    64'(v.idx));
        chk({name, ".stall"}, 64'(stall),        64'(v.stall));
        chk({name, ".cnt"},   64'(free_count),   64'(v.cnt));
        chk({name, ".dbl"},   64'(dbl_free_err), 64'(exp_dbl));
    endtask

    function automatic logic [PE-1:0] bit1(input int b);
        logic [PE-1:0] m;
        m = '0;
        m[b] = 1'b1;
        return m;
    endfunction

    initial begin
        logic [PE-1:0] rfv;

        tbl[0] = mk(3'b111, '0,        3'b111, 34, 33, 32, 1'b0, 32);
        tbl[1] = mk(3'b000, '0,        3'b000,  0,  0,  0, 1'b0, 29);
        tbl[2] = mk(3'b101, '0,        3'b101, 36,  0, 35, 1'b0, 29);
        tbl[3] = mk(3'b010, '0,        3'b010,  0, 37,  0, 1'b0, 27);
        tbl[4] = mk(3'b010, bit1(33),  3'b010,  0, 38,  0, 1'b0, 26);
        tbl[5] = mk(3'b001, '0,        3'b001,  0,  0, 33, 1'b0, 26);

        reset = 1'b1; recover = 1'b0; alloc_req = '0; free_vec = '0; recover_free_vec = '0;
        @(negedge clock);
        apply("reset_hold", 1'b1, 1'b0, '0, mk(3'b111, '0, 3'b000, 0, 0, 0, 1'b1, 32));

        for (int i = 0; i < 6; i++) begin
            apply($sformatf("tbl%0d", i), 1'b0, 1'b0, '0, tbl[i]);
        end

        for (int k = 0; k < 7; k++) begin
            apply($sformatf("drain%0d", k), 1'b0, 1'b0, '0,
                  mk(3'b111, '0, 3'b111, 41 + 3*k, 40 + 3*k, 39 + 3*k, 1'b0, 25 - 3*k));
        end
        apply("drain_last",   1'b0, 1'b0, '0, mk(3'b011, '0, 3'b011, 0, 61, 60, 1'b0, 4));
        apply("short_stall",  1'b0, 1'b0, '0, mk(3'b111, '0, 3'b000, 0, 0, 0, 1'b1, 2));
        apply("free_32_33",   1'b0, 1'b0, '0, mk(3'b000, bit1(32) | bit1(33), 3'b000, 0, 0, 0, 1'b0, 2));
        apply("lane_skip",    1'b0, 1'b0, '0, mk(3'b101, '0, 3'b101, 33, 0, 32, 1'b0, 4));
        apply("take_62_63",   1'b0, 1'b0, '0, mk(3'b011, '0, 3'b011, 0, 63, 62, 1'b0, 2));
        apply("no_bypass",    1'b0, 1'b0, '0, mk(3'b001, bit1(40), 3'b000, 0, 0, 0, 1'b1, 0));
        apply("freed_40",     1'b0, 1'b0, '0, mk(3'b001, '0, 3'b001, 0, 0, 40, 1'b0, 1));
        apply("free_bit0",    1'b0, 1'b0, '0, mk(3'b000, bit1(0), 3'b000, 0, 0, 0, 1'b0, 0));
        apply("bit0_ignored", 1'b0, 1'b0, '0, mk(3'b001, '0, 3'b000, 0, 0, 0, 1'b1, 0));

        rfv = bit1(0);
        for (int b = 50; b < 64; b++) rfv = rfv | bit1(b);
        apply("recover",      1'b0, 1'b1, rfv, mk(3'b111, '0, 3'b000, 0, 0, 0, 1'b1, 0));
        apply("post_recover", 1'b0, 1'b0, '0,  mk(3'b001, '0, 3'b001, 0, 0, 50, 1'b0, 14));
        apply("reset_mid",    1'b1, 1'b0, '0,  mk(3'b111, '0, 3'b000, 0, 0, 0, 1'b1, 13));
        apply("post_reset",   1'b0, 1'b0, '0,  mk(3'b001, '0, 3'b001, 0, 0, 32, 1'b0, 32));

        apply("dbl_free",     1'b0, 1'b0, '0,  mk(3'b000, bit1(60), 3'b000, 0, 0, 0, 1'b0, 31));
        exp_dbl = DBL_EN;
        apply("dbl_set",      1'b0, 1'b0, '0,  mk(3'b000, '0, 3'b000, 0, 0, 0, 1'b0, 31));
        apply("dbl_held",     1'b0, 1'b0, '0,  mk(3'b000, '0, 3'b000, 0, 0, 0, 1'b0, 31));
        apply("dbl_reset",    1'b1, 1'b0, '0,  mk(3'b000, '0, 3'b000, 0, 0, 0, 1'b1, 31));
        exp_dbl = 1'b0;
        apply("dbl_cleared",  1'b0, 1'b0, '0,  mk(3'b000, '0, 3'b000, 0, 0, 0, 1'b0, 32));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
